// File: rtl/axis_gen_pkg.sv
// Shared types and constants for the AXI4-Stream frame generator.
// Holds the FSM state encoding, PRBS-31 polynomial/seed and the frame_id position in tdata.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // x^31 + x^28 + 1
  localparam int          PRBS_ORDER     = 31;
  localparam int          PRBS_TAP       = 28;
  localparam logic [31:0] PRBS_SEED      = 32'h1;

  localparam int          FRAME_ID_SHIFT = 16;

endpackage

// File: rtl/axis_gen_prbs.sv
// PRBS-31 payload source: cur_o is the next unused DATA_W-bit word, nxt_o the one after it.
// The register advances DATA_W bits only when adv_i (a handshake) is high; no backpressure of its own.
module axis_gen_prbs
  import axis_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              adv_i,
  output logic [DATA_W-1:0] cur_o,
  output logic [DATA_W-1:0] nxt_o
);

  logic [PRBS_ORDER-1:0] state_q;
  logic [PRBS_ORDER-1:0] state_d;
  logic [PRBS_ORDER-1:0] s_c;
  logic                  b_c;

  // Bits are produced oldest-first into the MSB end of each word.
  always_comb begin
    s_c   = state_q;
    b_c   = 1'b0;
    cur_o = '0;
    nxt_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      b_c   = s_c[PRBS_ORDER-1] ^ s_c[PRBS_TAP-1];
      s_c   = {s_c[PRBS_ORDER-2:0], b_c};
      cur_o = {cur_o[DATA_W-2:0], b_c};
    end
    state_d = s_c;
    for (int i = 0; i < DATA_W; i++) begin
      b_c   = s_c[PRBS_ORDER-1] ^ s_c[PRBS_TAP-1];
      s_c   = {s_c[PRBS_ORDER-2:0], b_c};
      nxt_o = {nxt_o[DATA_W-2:0], b_c};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PRBS_SEED[PRBS_ORDER-1:0];
    end else if (adv_i) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: runs of frames with idle gaps; all outputs registered and held while tready is low.
// Define AXIS_FRAME_GEN_PRBS_EN to replace the frame_id/beat_idx payload with a PRBS-31 stream.
module axis_frame_gen
  import axis_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W/8,
  parameter int USER_W = 1,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic [15:0]       num_frames,
  output logic              busy,
  output logic [31:0]       frames_sent,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic [USER_W-1:0] m_axis_tuser
);

  localparam int             LW1 = LEN_W + 1;
  localparam logic [LEN_W:0] KW  = LW1'(KEEP_W);
  localparam logic [LEN_W:0] ONE = LW1'(1);

  state_t            state_q;
  logic              busy_q, stop_pend_q, tvalid_q, tlast_q;
  logic [LEN_W-1:0]  beat_idx_q, last_idx_q;
  logic [KEEP_W-1:0] last_keep_q, tkeep_q;
  logic [GAP_W-1:0]  gap_q, gap_cnt_q;
  logic [15:0]       nf_q, run_cnt_q;
  logic [31:0]       frames_sent_q;
  logic [DATA_W-1:0] tdata_q;
  logic [USER_W-1:0] tuser_q;

  logic [LEN_W:0]    len_eff, beats, rem;
  logic [LEN_W-1:0]  last_idx_d, nxt_idx;
  logic [KEEP_W-1:0] last_keep_d;
  logic              nxt_last, run_done, end_req, hs;
  logic [DATA_W-1:0] data_first, data_next;

  always_comb begin
    len_eff     = (frame_len == '0) ? KW : {1'b0, frame_len};
    beats       = (len_eff + KW - ONE) / KW;
    rem         = len_eff % KW;
    last_idx_d  = LEN_W'(beats - ONE);
    last_keep_d = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      last_keep_d[i] = (rem == '0) || (LW1'(i) < rem);
    end
    nxt_idx  = beat_idx_q + LEN_W'(1);
    nxt_last = (nxt_idx == last_idx_q);
    run_done = (nf_q != 16'd0) && (run_cnt_q + 16'd1 == nf_q);
    end_req  = stop_pend_q || stop;
    hs       = tvalid_q && m_axis_tready;
  end

  // frames_sent only moves on the last beat, so its low half is the frame_id for the whole frame.
`ifdef AXIS_FRAME_GEN_PRBS_EN
  logic [DATA_W-1:0] prbs_cur, prbs_nxt;

  axis_gen_prbs #(.DATA_W(DATA_W)) u_prbs (
    .clk_i (aclk),
    .rst_ni(aresetn),
    .adv_i (hs),
    .cur_o (prbs_cur),
    .nxt_o (prbs_nxt)
  );

  assign data_first = prbs_cur;
  assign data_next  = prbs_nxt;
`else
  assign data_first = DATA_W'(frames_sent_q[15:0]) << FRAME_ID_SHIFT;
  assign data_next  = (DATA_W'(frames_sent_q[15:0]) << FRAME_ID_SHIFT) + DATA_W'(nxt_idx);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      stop_pend_q   <= 1'b0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tkeep_q       <= '0;
      tdata_q       <= '0;
      tuser_q       <= '0;
      beat_idx_q    <= '0;
      last_idx_q    <= '0;
      last_keep_q   <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      nf_q          <= '0;
      run_cnt_q     <= '0;
      frames_sent_q <= '0;
    end else begin
      if (stop) stop_pend_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_LOAD;
            busy_q      <= 1'b1;
            run_cnt_q   <= '0;
            stop_pend_q <= stop;
          end
        end
        ST_LOAD: begin
          nf_q        <= num_frames;
          gap_q       <= gap_cycles;
          last_idx_q  <= last_idx_d;
          last_keep_q <= last_keep_d;
          beat_idx_q  <= '0;
          if (end_req) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
          end else begin
            state_q  <= ST_SEND;
            tvalid_q <= 1'b1;
            tdata_q  <= data_first;
            tuser_q  <= USER_W'(1);
            tlast_q  <= (last_idx_d == '0);
            tkeep_q  <= (last_idx_d == '0) ? last_keep_d : '1;
          end
        end
        ST_SEND: begin
          if (hs && tlast_q) begin
            frames_sent_q <= frames_sent_q + 32'd1;
            run_cnt_q     <= run_cnt_q + 16'd1;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tkeep_q       <= '0;
            tdata_q       <= '0;
            tuser_q       <= '0;
            if (end_req || run_done) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= gap_q;
            end
          end else if (hs) begin
            beat_idx_q <= nxt_idx;
            tdata_q    <= data_next;
            tuser_q    <= '0;
            tlast_q    <= nxt_last;
            tkeep_q    <= nxt_last ? last_keep_q : '1;
          end
        end
        ST_GAP: begin
          // A zero gap still spends one cycle here.
          if (end_req) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
          end else if (gap_cnt_q <= GAP_W'(1)) begin
            state_q <= ST_LOAD;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign frames_sent   = frames_sent_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: a frame-level model queue checked on every handshake, plus literal pins.
module tb_axis_frame_gen;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] frame_len = '0;
  logic [7:0]  gap_cycles = '0;
  logic [15:0] num_frames = '0;
  logic        busy;
  logic [31:0] frames_sent;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;

  axis_frame_gen #(.DATA_W(32), .KEEP_W(4), .USER_W(1), .LEN_W(16), .GAP_W(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
    .frame_len(frame_len), .gap_cycles(gap_cycles), .num_frames(num_frames),
    .busy(busy), .frames_sent(frames_sent),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_keep[$];
  logic        log_last[$];
  logic        log_user[$];
  int          idle_q[$];

  int total = 0;
  int bad   = 0;
  logic toggle = 1'b0;
  logic [30:0] m_lfsr = 31'h1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // One frame of the spec's payload rule: ceil(len/4) beats, zero length means one full beat.
  task automatic push_frame(input int len, input int fid);
    int nb, rem, k;
    beat_t b;
    nb  = (len == 0) ? 1 : (len + 3) / 4;
    rem = len % 4;
    for (int i = 0; i < nb; i++) begin
      k      = (rem == 0) ? 15 : (1 << rem) - 1;
      b.data = (fid << 16) + i;
      b.keep = (i == nb - 1) ? k[3:0] : 4'hF;
      b.last = (i == nb - 1);
      b.user = (i == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_logs();
    log_data.delete(); log_keep.delete(); log_last.delete(); log_user.delete(); idle_q.delete();
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    exp_q.delete();
    m_lfsr = 31'h1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    clear_logs();
  endtask

  task automatic pulse_start();
    @(negedge aclk); start = 1'b1;
    @(negedge aclk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge aclk); stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge aclk);
      n++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  initial forever begin
    @(posedge aclk);
    #1;
    if (toggle) m_axis_tready = !m_axis_tready;
    else        m_axis_tready = 1'b1;
  end

  // Compare process: every handshake against the model, stall stability, idle-cycle counting.
  logic        stall_prev = 1'b0;
  logic        tv_prev = 1'b0;
  int          idle_cnt = 0;
  beat_t       mon_e;
  logic [31:0] prev_data, mon_w;
  logic [3:0]  prev_keep;
  logic        prev_last, prev_user, mon_b;

  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
      tv_prev    = 1'b0;
      idle_cnt   = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("stall_data", m_axis_tdata, prev_data);
        chk("stall_ctl", {26'd0, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
            {26'd0, prev_keep, prev_last, prev_user});
      end
      if (m_axis_tvalid && !tv_prev) begin
        idle_q.push_back(idle_cnt);
        idle_cnt = 0;
      end else if (busy && !m_axis_tvalid) begin
        idle_cnt++;
      end else if (!busy) begin
        idle_cnt = 0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        log_data.push_back(m_axis_tdata);
        log_keep.push_back(m_axis_tkeep);
        log_last.push_back(m_axis_tlast);
        log_user.push_back(m_axis_tuser[0]);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", m_axis_tdata, 32'hDEAD_BEEF);
        end else begin
          mon_e = exp_q.pop_front();
`ifdef AXIS_FRAME_GEN_PRBS_EN
          mon_w = '0;
          for (int k = 0; k < 32; k++) begin
            mon_b  = m_lfsr[30] ^ m_lfsr[27];
            m_lfsr = {m_lfsr[29:0], mon_b};
            mon_w  = {mon_w[30:0], mon_b};
          end
          mon_e.data = mon_w;
`endif
          chk("beat_data", m_axis_tdata, mon_e.data);
          chk("beat_keep", {28'd0, m_axis_tkeep}, {28'd0, mon_e.keep});
          chk("beat_last", {31'd0, m_axis_tlast}, {31'd0, mon_e.last});
          chk("beat_user", {31'd0, m_axis_tuser}, {31'd0, mon_e.user});
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      tv_prev    = m_axis_tvalid;
      prev_data  = m_axis_tdata;
      prev_keep  = m_axis_tkeep;
      prev_last  = m_axis_tlast;
      prev_user  = m_axis_tuser[0];
    end
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frames", frames_sent, 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_ctl", {26'd0, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 32'd0);
    aresetn = 1'b1;
    clear_logs();

    // 10-byte single frame; inputs changed mid-frame must not matter
    frame_len = 16'd10; num_frames = 16'd1; gap_cycles = 8'd0;
    push_frame(10, 0);
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    @(negedge aclk);
    frame_len = 16'd40; num_frames = 16'd5;
    wait_idle(50, "t1_idle");
    chk("t1_frames", frames_sent, 32'd1);
    chk("t1_nbeats", log_data.size(), 32'd3);
    chk("t1_model_empty", exp_q.size(), 32'd0);
    if (log_data.size() == 3) begin
`ifdef AXIS_FRAME_GEN_PRBS_EN
      chk("t1_prbs_first", log_data[0], 32'h0000_0012);
`else
      chk("t1_data0", log_data[0], 32'h0);
      chk("t1_data2", log_data[2], 32'h2);
`endif
      chk("t1_keep_last", {28'd0, log_keep[2]}, 32'h3);
      chk("t1_tlast", {29'd0, log_last[2], log_last[1], log_last[0]}, 32'b100);
      chk("t1_tuser", {29'd0, log_user[2], log_user[1], log_user[0]}, 32'b001);
    end

    // Three 16-byte frames, gap 2, tready toggling; a start while busy is ignored
    do_reset();
    frame_len = 16'd16; num_frames = 16'd3; gap_cycles = 8'd2;
    for (int f = 0; f < 3; f++) push_frame(16, f);
    toggle = 1'b1;
    pulse_start();
    repeat (6) @(negedge aclk);
    start = 1'b1;
    @(negedge aclk); start = 1'b0;
    wait_idle(300, "t2_idle");
    toggle = 1'b0;
    chk("t2_frames", frames_sent, 32'd3);
    chk("t2_nbeats", log_data.size(), 32'd12);
    chk("t2_model_empty", exp_q.size(), 32'd0);
    chk("t2_idle_runs", idle_q.size(), 32'd3);
    if (idle_q.size() == 3) begin
      chk("t2_idle_first", idle_q[0], 32'd1);
      chk("t2_idle_gap1", idle_q[1], 32'd3);
      chk("t2_idle_gap2", idle_q[2], 32'd3);
    end
`ifndef AXIS_FRAME_GEN_PRBS_EN
    if (log_data.size() == 12) chk("t2_frame2_data", log_data[4], 32'h0001_0000);
`endif

    // Continuous run, stop during frame 5
    do_reset();
    frame_len = 16'd8; num_frames = 16'd0; gap_cycles = 8'd1;
    for (int f = 0; f < 5; f++) push_frame(8, f);
    pulse_start();
    n = 0;
    while (!(frames_sent == 32'd4 && m_axis_tvalid) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("t3_reach_f5", {31'd0, (frames_sent == 32'd4 && m_axis_tvalid)}, 32'd1);
    pulse_stop();
    wait_idle(50, "t3_idle");
    repeat (20) @(negedge aclk);
    chk("t3_frames", frames_sent, 32'd5);
    chk("t3_nbeats", log_data.size(), 32'd10);
    chk("t3_model_empty", exp_q.size(), 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset during beat 2 of a 4-beat frame
    do_reset();
    frame_len = 16'd16; num_frames = 16'd1; gap_cycles = 8'd0;
    push_frame(16, 0);
    pulse_start();
    n = 0;
    while (log_data.size() < 2 && n < 50) begin
      @(negedge aclk);
      #1;
      n++;
    end
    chk("t4_reach_beat2", log_data.size(), 32'd2);
    #1;
    aresetn = 1'b0;
    #1;
    chk("t4_async_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("t4_async_frames", frames_sent, 32'd0);
    chk("t4_async_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    m_lfsr = 31'h1;
    @(negedge aclk);
    aresetn = 1'b1;
    clear_logs();
    push_frame(16, 0);
    pulse_start();
    wait_idle(50, "t4_idle");
    chk("t4_frames", frames_sent, 32'd1);
    chk("t4_nbeats", log_data.size(), 32'd4);
    if (log_data.size() == 4) begin
`ifndef AXIS_FRAME_GEN_PRBS_EN
      chk("t4_data0", log_data[0], 32'h0);
`endif
      chk("t4_user0", {31'd0, log_user[0]}, 32'd1);
    end

    // Zero length -> one full beat
    do_reset();
    frame_len = 16'd0; num_frames = 16'd1;
    push_frame(0, 0);
    pulse_start();
    wait_idle(50, "t5_idle");
    chk("t5_nbeats", log_data.size(), 32'd1);
    if (log_data.size() == 1) begin
      chk("t5_keep", {28'd0, log_keep[0]}, 32'hF);
      chk("t5_last_user", {30'd0, log_last[0], log_user[0]}, 32'b11);
    end

    // Stop during the inter-frame gap ends the run with no further frame
    do_reset();
    frame_len = 16'd4; num_frames = 16'd0; gap_cycles = 8'd5;
    push_frame(4, 0);
    pulse_start();
    n = 0;
    while (frames_sent != 32'd1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    @(negedge aclk);
    pulse_stop();
    wait_idle(50, "t6_idle");
    repeat (15) @(negedge aclk);
    chk("t6_frames", frames_sent, 32'd1);
    chk("t6_nbeats", log_data.size(), 32'd1);
    chk("t6_model_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
